axis_dsp_mac: RTL and testbench
===============================

Name: axis_dsp_mac

Overview:
- Parametrised, AXI-Stream-handshaked successor to the fixed pre-add/multiply/compare DSP slice.
- Computes a pre-adder/multiplier result per beat: (d ± a) * b, or a * b.
- Pattern-detects the result against operand c, with a maskable compare.
- Fully stallable 3-stage pipeline; optional per-packet accumulator.
- Sits between the stream sample source and downstream filter/sink blocks in the DSP datapath.

Parameters:
- DATA_WIDTH, 16, width of operands a, b, c, d (signed two's complement).
- P_WIDTH, 48, width of result p; must be >= 2*DATA_WIDTH+2.
- PD_MASK, {P_WIDTH{1'b0}}, bits set to 1 are ignored by pattern detect.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last beat of packet.
- mode  in  2  op select, sampled with beat: 00 (d+a)*b, 01 (d-a)*b, 10 a*b, 11 treated as 00.
- a  in  DATA_WIDTH  operand a.
- b  in  DATA_WIDTH  operand b.
- c  in  DATA_WIDTH  pattern operand, sign-extended to P_WIDTH.
- d  in  DATA_WIDTH  operand d.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  tlast of the originating beat.
- p  out  P_WIDTH  signed result.
- pd  out  1  pattern detect for the beat carried on p.

Behaviour:
- Reset, rst=0 sampled at a clock edge:
  - All stage valids cleared.
  - m_axis_tvalid=0, m_axis_tlast=0, p=0, pd=0.
  - Accumulator cleared.
  - In-flight beats are discarded.
  - s_axis_tready=0 while rst=0.
- Pipeline enable: en = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = en (when not in reset).
  - All stages, including valid bits, advance only when en=1; otherwise every stage holds.
- Stage 1, on input handshake:
  - pre = sext(d) ± sext(a), DATA_WIDTH+1 bits, no overflow possible.
  - Mode 10 gives pre = sext(a).
  - b, c, tlast and mode are registered alongside.
  - A bubble (tvalid=0 with en=1) loads valid=0.
- Stage 2: prod = pre * b, signed, 2*DATA_WIDTH+1 bits.
- Stage 3, output register:
  - p = sext(prod) to P_WIDTH.
  - pd = (((p_next ^ sext(c)) & ~PD_MASK) == 0).
  - pd is computed on the same value being loaded into p.
  - m_axis_tvalid = stage-2 valid, m_axis_tlast = stage-2 tlast.
- Latency: exactly 3 clocks from input handshake to m_axis_tvalid with no backpressure. Throughput is 1 beat/clock.
- p, pd and tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-S rule).
- Simultaneous output handshake and input handshake in the same cycle: both occur; no bubble is inserted.
- m_axis_tready is ignored when m_axis_tvalid=0; the pipeline flows and bubbles are collapsed.
- Reset mid-packet: the packet is dropped. The next beat after reset starts a fresh packet (accumulator is 0).

Optional Feature:
- Macro: AXIS_DSP_ACC_EN.
- Defined:
  - Stage 3 computes p = acc + sext(prod), wrapping modulo 2^P_WIDTH.
  - acc updates on every stage-3 load of a valid beat.
  - acc clears to 0 after loading a beat with tlast=1, so the next packet starts from 0.
  - pd compares the accumulated p.
- Undefined: no accumulator register; p = sext(prod) per beat.

Test Plan:
- Basic pre-add: mode 00, a=3, d=5, b=4, c=32, m_axis_tready=1 -> 3 clocks later p=32, pd=1, m_axis_tvalid=1 for one cycle.
- Subtract and sign: mode 01, d=2, a=7, b=3, c=0 -> p=-15 (all upper bits 1), pd=0. Then mode 10, a=-4, b=-5 -> p=20.
- Extremes: mode 00, d=a=32767, b=-32768 -> p=-2147418112 exact, with no truncation at P_WIDTH=48.
- Backpressure:
  - Stream 6 beats (p = 1..6) back-to-back.
  - Drop m_axis_tready for 4 cycles after the 2nd output.
  - Expect: p holds 2 stable; s_axis_tready=0 while stalled; all 6 results emerge in order with none lost or duplicated; tlast on the 6th.
- Pattern mask: PD_MASK=0xF, result 0x123, c=0x120 -> pd=1. Same values with PD_MASK=0 -> pd=0.
- Reset mid-flight:
  - Assert rst=0 for one cycle with 2 beats in the pipe -> no output from them; m_axis_tvalid=0, p=0 next cycle.
  - With AXIS_DSP_ACC_EN: beats 2,3,tlast 4 (b=1, a=0) -> p=2,5,9, then next packet's first beat 1 -> p=1.

Source files
------------

// File: rtl/axis_dsp_mac_if.sv
// axis_dsp_mac_if: stream bundle for the pre-add/multiply/pattern-detect MAC.
// Carries the input beat (handshake, tlast, mode and the a/b/c/d operands) and
// the output beat (handshake, tlast, result p and pattern-detect flag pd).
// The slave modport is the MAC's view; the master modport is the view of
// whatever feeds it and consumes its results.
interface axis_dsp_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int P_WIDTH    = 48
);
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] c;
  logic [DATA_WIDTH-1:0] d;

  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [P_WIDTH-1:0]    p;
  logic                  pd;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, mode, a, b, c, d, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, p, pd
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, mode, a, b, c, d, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, p, pd
  );
endinterface

// File: rtl/axis_dsp_mac.sv
// axis_dsp_mac: stallable 3-stage DSP slice with stream handshakes.
//   stage 1: pre = d + a, d - a or a (mode 11 behaves like 00)
//   stage 2: prod = pre * b (signed, full precision)
//   stage 3: p = sext(prod) (+ running accumulator), pd = masked compare with c
// Optional build macro AXIS_DSP_ACC_EN adds a per-packet accumulator: p is the
// running sum of products within a packet and restarts at 0 after tlast.
// Reset is synchronous and active-low on rst.
module axis_dsp_mac #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   P_WIDTH    = 48,
  parameter logic [P_WIDTH-1:0]   PD_MASK    = '0
) (
  input  logic           clk,
  input  logic           rst,
  axis_dsp_mac_if.slave  bus
);

  localparam int PRE_W  = DATA_WIDTH + 1;
  localparam int PROD_W = 2 * DATA_WIDTH + 1;

  // pipeline enable: every stage moves only when the output slot is free or draining
  logic en;

  logic                  v1_q, v1_d;
  logic [PRE_W-1:0]      pre1_q, pre1_d;
  logic [DATA_WIDTH-1:0] b1_q, b1_d;
  logic [DATA_WIDTH-1:0] c1_q, c1_d;
  logic                  last1_q, last1_d;

  logic                  v2_q, v2_d;
  logic [PROD_W-1:0]     prod2_q, prod2_d;
  logic [DATA_WIDTH-1:0] c2_q, c2_d;
  logic                  last2_q, last2_d;

  logic                  v3_q, v3_d;
  logic [P_WIDTH-1:0]    p3_q, p3_d;
  logic                  pd3_q, pd3_d;
  logic                  last3_q, last3_d;

  logic [PRE_W-1:0]      a_ext, d_ext;
  logic [PROD_W-1:0]     pre_wide, b_wide;
  logic [P_WIDTH-1:0]    prod_ext, c_ext, acc_base, p_next;

  assign en = !v3_q || bus.m_axis_tready;

  assign bus.s_axis_tready = rst && en;
  assign bus.m_axis_tvalid = v3_q;
  assign bus.m_axis_tlast  = last3_q;
  assign bus.p             = p3_q;
  assign bus.pd            = pd3_q;

  // stage 1: form the pre-adder result from the incoming beat; a bubble loads valid=0
  always_comb begin
    a_ext   = {bus.a[DATA_WIDTH-1], bus.a};
    d_ext   = {bus.d[DATA_WIDTH-1], bus.d};
    v1_d    = v1_q;
    pre1_d  = pre1_q;
    b1_d    = b1_q;
    c1_d    = c1_q;
    last1_d = last1_q;
    if (en) begin
      v1_d    = bus.s_axis_tvalid;
      b1_d    = bus.b;
      c1_d    = bus.c;
      last1_d = bus.s_axis_tlast;
      case (bus.mode)
        2'b01:   pre1_d = d_ext - a_ext;
        2'b10:   pre1_d = a_ext;
        default: pre1_d = d_ext + a_ext;
      endcase
    end
  end

  // stage 2: full-precision signed multiply; sign-extended operands make the low PROD_W bits exact
  always_comb begin
    pre_wide = {{(PROD_W-PRE_W){pre1_q[PRE_W-1]}}, pre1_q};
    b_wide   = {{(PROD_W-DATA_WIDTH){b1_q[DATA_WIDTH-1]}}, b1_q};
    v2_d     = v2_q;
    prod2_d  = prod2_q;
    c2_d     = c2_q;
    last2_d  = last2_q;
    if (en) begin
      v2_d    = v1_q;
      prod2_d = pre_wide * b_wide;
      c2_d    = c1_q;
      last2_d = last1_q;
    end
  end

`ifdef AXIS_DSP_ACC_EN
  logic [P_WIDTH-1:0] acc_q, acc_d;

  assign acc_base = acc_q;

  // accumulator follows each loaded beat and restarts from zero after the packet's last beat
  always_comb begin
    acc_d = acc_q;
    if (en && v2_q) begin
      acc_d = last2_q ? '0 : p_next;
    end
  end

  // accumulator register, cleared by reset so a dropped packet leaves nothing behind
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign acc_base = '0;
`endif

  // stage 3: widen the product, add the running sum, and pattern-detect on that same value
  always_comb begin
    prod_ext = {{(P_WIDTH-PROD_W){prod2_q[PROD_W-1]}}, prod2_q};
    c_ext    = {{(P_WIDTH-DATA_WIDTH){c2_q[DATA_WIDTH-1]}}, c2_q};
    p_next   = acc_base + prod_ext;
    v3_d     = v3_q;
    p3_d     = p3_q;
    pd3_d    = pd3_q;
    last3_d  = last3_q;
    if (en) begin
      v3_d = v2_q;
      if (v2_q) begin
        p3_d    = p_next;
        pd3_d   = (((p_next ^ c_ext) & ~PD_MASK) == '0);
        last3_d = last2_q;
      end
    end
  end

  // pipeline registers: valids and visible outputs clear on reset, payload just follows _d
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p3_q    <= '0;
      pd3_q   <= 1'b0;
      last3_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      p3_q    <= p3_d;
      pd3_q   <= pd3_d;
      last3_q <= last3_d;
    end
    pre1_q  <= pre1_d;
    b1_q    <= b1_d;
    c1_q    <= c1_d;
    last1_q <= last1_d;
    prod2_q <= prod2_d;
    c2_q    <= c2_d;
    last2_q <= last2_d;
  end

endmodule

// File: tb/tb_axis_dsp_mac.sv
// tb_axis_dsp_mac: randomized and directed stimulus for axis_dsp_mac, scored
// against an arithmetic reference model of the slice held in a queue.
// Honours AXIS_DSP_ACC_EN the same way the design does.
module tb_axis_dsp_mac;

  localparam int             DW   = 16;
  localparam int             PW   = 48;
  localparam logic [PW-1:0]  MASK = 48'hF;

  typedef struct {
    logic [PW-1:0] p;
    logic          pd;
    logic          last;
    int            inCycle;
    int            stallMark;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  axis_dsp_mac_if #(.DATA_WIDTH(DW), .P_WIDTH(PW)) bus ();

  axis_dsp_mac #(
    .DATA_WIDTH (DW),
    .P_WIDTH    (PW),
    .PD_MASK    (MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running clock, 10 time units per period
  always #5 clk = ~clk;

  expT           expQ[$];
  expT           expItem;
  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            stallCount = 0;
  bit            randReady = 1'b0;
  bit            prevRst = 1'b1;
  bit            holdValid = 1'b0;
  logic [PW-1:0] holdP;
  logic          holdPd;
  logic          holdLast;
  logic [PW-1:0] lastOutP = '0;
  logic          lastOutPd = 1'b0;
  longint        mA, mB, mD, mPre, mProd;
  logic [PW-1:0] mPv, mC;
`ifdef AXIS_DSP_ACC_EN
  logic [PW-1:0] modelAcc = '0;
`endif

  // every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // monitor: scores accepted beats with the model and checks every emitted result
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      expQ.delete();
`ifdef AXIS_DSP_ACC_EN
      modelAcc = '0;
`endif
      holdValid = 1'b0;
      prevRst   = 1'b0;
      checkOutput("readyInReset", 64'(bus.s_axis_tready), 64'(0));
    end else begin
      if (!prevRst) begin
        checkOutput("rstValid", 64'(bus.m_axis_tvalid), 64'(0));
        checkOutput("rstP",     64'(bus.p),             64'(0));
        checkOutput("rstPd",    64'(bus.pd),            64'(0));
        checkOutput("rstLast",  64'(bus.m_axis_tlast),  64'(0));
      end
      prevRst = 1'b1;
      checkOutput("readyRule", 64'(bus.s_axis_tready), 64'(!bus.m_axis_tvalid || bus.m_axis_tready));
      if (holdValid) begin
        checkOutput("holdValid", 64'(bus.m_axis_tvalid), 64'(1));
        checkOutput("holdP",     64'(bus.p),             64'(holdP));
        checkOutput("holdPd",    64'(bus.pd),            64'(holdPd));
        checkOutput("holdLast",  64'(bus.m_axis_tlast),  64'(holdLast));
      end
      holdValid = bus.m_axis_tvalid && !bus.m_axis_tready;
      holdP     = bus.p;
      holdPd    = bus.pd;
      holdLast  = bus.m_axis_tlast;

      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        mA = longint'($signed(bus.a));
        mB = longint'($signed(bus.b));
        mD = longint'($signed(bus.d));
        case (bus.mode)
          2'b01:   mPre = mD - mA;
          2'b10:   mPre = mA;
          default: mPre = mD + mA;
        endcase
        mProd = mPre * mB;
`ifdef AXIS_DSP_ACC_EN
        mPv = modelAcc + PW'(mProd);
        modelAcc = bus.s_axis_tlast ? '0 : mPv;
`else
        mPv = PW'(mProd);
`endif
        mC = PW'(longint'($signed(bus.c)));
        expItem.p         = mPv;
        expItem.pd        = (((mPv ^ mC) & ~MASK) == '0);
        expItem.last      = bus.s_axis_tlast;
        expItem.inCycle   = cycle;
        expItem.stallMark = stallCount;
        expQ.push_back(expItem);
      end

      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOut", 64'(1), 64'(0));
        end else begin
          expItem = expQ.pop_front();
          checkOutput("p",     64'(bus.p),            64'(expItem.p));
          checkOutput("pd",    64'(bus.pd),           64'(expItem.pd));
          checkOutput("tlast", 64'(bus.m_axis_tlast), 64'(expItem.last));
          if (stallCount == expItem.stallMark) begin
            checkOutput("latency", 64'(cycle - expItem.inCycle), 64'(3));
          end
        end
        lastOutP  = bus.p;
        lastOutPd = bus.pd;
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
        stallCount++;
      end
    end
  end

  // advance one clock and re-roll downstream ready when backpressure is randomized
  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) begin
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // present one beat and hold it until the slice accepts it
  task automatic applyStimulus(input logic [1:0] md, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                               input logic [DW-1:0] cv, input logic [DW-1:0] dv, input logic lst);
    bit accepted;
    int guard;
    bus.mode          = md;
    bus.a             = av;
    bus.b             = bv;
    bus.c             = cv;
    bus.d             = dv;
    bus.s_axis_tlast  = lst;
    bus.s_axis_tvalid = 1'b1;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 200) begin
      @(negedge clk);
      accepted = bus.s_axis_tready;
      guard++;
      tick();
    end
    if (!accepted) begin
      checkOutput("acceptTimeout", 64'(0), 64'(1));
    end
    bus.s_axis_tvalid = 1'b0;
  endtask

  // let every outstanding result leave with ready held high
  task automatic drain();
    int guard;
    randReady         = 1'b0;
    bus.m_axis_tready = 1'b1;
    guard = 0;
    while (expQ.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drainTimeout", 64'(expQ.size()), 64'(0));
    end
    tick();
  endtask

  // one-clock reset pulse
  task automatic pulseReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // hard stop in case anything above ever fails to return
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // main test sequence
  initial begin
    logic [DW-1:0] ra, rb, rc, rd;
    logic [1:0]    rm;
    int            guard;

    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.mode          = 2'b00;
    bus.a             = '0;
    bus.b             = '0;
    bus.c             = '0;
    bus.d             = '0;
    bus.m_axis_tready = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    applyStimulus(2'b00, 16'd3, 16'd4, 16'd32, 16'd5, 1'b1);
    drain();
    checkOutput("basicP",  64'(lastOutP),  64'(32));
    checkOutput("basicPd", 64'(lastOutPd), 64'(1));

    applyStimulus(2'b01, 16'd7, 16'd3, 16'd0, 16'd2, 1'b1);
    drain();
    checkOutput("subP",  64'(lastOutP),  64'h0000_FFFF_FFFF_FFF1);
    checkOutput("subPd", 64'(lastOutPd), 64'(0));

    applyStimulus(2'b10, 16'hFFFC, 16'hFFFB, 16'd0, 16'd0, 1'b1);
    drain();
    checkOutput("mulP", 64'(lastOutP), 64'(20));

    applyStimulus(2'b00, 16'h7FFF, 16'h8000, 16'd0, 16'h7FFF, 1'b1);
    drain();
    checkOutput("extremeP", 64'(lastOutP), 64'h0000_FFFF_8001_0000);

    applyStimulus(2'b10, 16'h0123, 16'd1, 16'h0120, 16'd0, 1'b1);
    drain();
    checkOutput("maskHit", 64'(lastOutPd), 64'(1));
    applyStimulus(2'b10, 16'h0123, 16'd1, 16'h0100, 16'd0, 1'b1);
    drain();
    checkOutput("maskMiss", 64'(lastOutPd), 64'(0));

    bus.m_axis_tready = 1'b1;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          applyStimulus(2'b10, DW'(k), 16'd1, DW'(k), 16'd0, (k == 6));
        end
      end
      begin
        guard = 0;
        forever begin
          @(negedge clk);
          guard++;
          if ((bus.m_axis_tvalid && bus.m_axis_tready) || guard > 50) break;
        end
        if (guard > 50) begin
          checkOutput("bpFirstOutTimeout", 64'(0), 64'(1));
        end
        @(posedge clk);
        #1;
        bus.m_axis_tready = 1'b0;
        repeat (4) begin
          @(negedge clk);
`ifdef AXIS_DSP_ACC_EN
          checkOutput("bpHoldP", 64'(bus.p), 64'(3));
`else
          checkOutput("bpHoldP", 64'(bus.p), 64'(2));
`endif
          checkOutput("bpStallReady", 64'(bus.s_axis_tready), 64'(0));
          @(posedge clk);
          #1;
        end
        bus.m_axis_tready = 1'b1;
      end
    join
    drain();

    applyStimulus(2'b10, 16'h0055, 16'd1, 16'd0, 16'd0, 1'b0);
    applyStimulus(2'b10, 16'h0066, 16'd1, 16'd0, 16'd0, 1'b0);
    pulseReset();
    repeat (6) begin
      @(negedge clk);
      checkOutput("rstNoOut", 64'(bus.m_axis_tvalid), 64'(0));
      tick();
    end

    applyStimulus(2'b00, 16'd0, 16'd1, 16'd0, 16'd2, 1'b0);
    applyStimulus(2'b00, 16'd0, 16'd1, 16'd0, 16'd3, 1'b0);
    applyStimulus(2'b00, 16'd0, 16'd1, 16'd0, 16'd4, 1'b1);
    drain();
`ifdef AXIS_DSP_ACC_EN
    checkOutput("accPacketP", 64'(lastOutP), 64'(9));
`else
    checkOutput("accPacketP", 64'(lastOutP), 64'(4));
`endif
    applyStimulus(2'b00, 16'd0, 16'd1, 16'd0, 16'd7, 1'b0);
    drain();
    pulseReset();
    tick();
    applyStimulus(2'b00, 16'd0, 16'd1, 16'd0, 16'd1, 1'b1);
    drain();
    checkOutput("freshPacketP", 64'(lastOutP), 64'(1));

    randReady = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rm = 2'($urandom_range(0, 3));
      if (n % 2 == 0) begin
        ra = DW'(int'($urandom_range(0, 16)) - 8);
        rb = DW'(int'($urandom_range(0, 16)) - 8);
        rd = DW'(int'($urandom_range(0, 16)) - 8);
        rc = DW'(int'($urandom_range(0, 64)) - 32);
      end else begin
        ra = DW'($urandom);
        rb = DW'($urandom);
        rd = DW'($urandom);
        rc = DW'($urandom);
      end
      applyStimulus(rm, ra, rb, rc, rd, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
